// File: rtl/demux_pkg.sv
// Shared types and constants for the 4-channel TDM demultiplexer.
// Imported by the slot counter and the top level.
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_e;

endpackage

// File: rtl/demux_slot_ctr.sv
// Modulo-4 slot index with load-to-1, increment and clear controls.
// last_slot_o flags the final slot of a frame.
module demux_slot_ctr
  import demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load1_i,
  input  logic              inc_i,
  input  logic              clr_i,
  output logic [SLOT_W-1:0] slot_o,
  output logic              last_slot_o
);

  logic [SLOT_W-1:0] cnt_q;
  logic [SLOT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    unique case (1'b1)
      clr_i:   cnt_d = '0;
      load1_i: cnt_d = SLOT_W'(1);
      inc_i:   cnt_d = cnt_q + SLOT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign slot_o      = cnt_q;
  assign last_slot_o = (cnt_q == SLOT_W'(NUM_CH - 1));

endmodule

// File: rtl/demux4_tdm.sv
// Time-division 1-to-4 demultiplexer with atomic frame commit.
// Slots 0..2 are staged in shadow registers; slot 3 goes straight to y.
module demux4_tdm
  import demux_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    frame_start,
  input  logic [WIDTH-1:0]        din,
  output logic [NUM_CH*WIDTH-1:0] y,
  output logic                    frame_valid,
  output logic [SLOT_W-1:0]       slot,
  output logic                    sync_err
);

  state_e state_q;
  state_e state_d;

  logic [WIDTH-1:0]        shadow_q [NUM_CH-1];
  logic [NUM_CH*WIDTH-1:0] y_q;
  logic                    fv_q;
  logic                    fv_d;
  logic                    se_q;
  logic                    se_d;

  logic              ld1;
  logic              inc;
  logic              clr;
  logic              sh_we;
  logic [SLOT_W-1:0] sh_idx;
  logic              commit;
  logic              last_slot;

  demux_slot_ctr u_slot_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .load1_i     (ld1),
    .inc_i       (inc),
    .clr_i       (clr),
    .slot_o      (slot),
    .last_slot_o (last_slot)
  );

  always_comb begin
    state_d = state_q;
    ld1     = 1'b0;
    inc     = 1'b0;
    clr     = 1'b0;
    sh_we   = 1'b0;
    sh_idx  = slot;
    commit  = 1'b0;
    fv_d    = 1'b0;
    se_d    = 1'b0;
    if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            ld1     = 1'b1;
            sh_we   = 1'b1;
            sh_idx  = '0;
            state_d = COLLECT;
          end else begin
            se_d = 1'b1;
          end
        end
        COLLECT: begin
          if (frame_start) begin
            // Early restart: drop the partial frame, this sample is slot 0
            se_d   = 1'b1;
            ld1    = 1'b1;
            sh_we  = 1'b1;
            sh_idx = '0;
          end else if (last_slot) begin
            commit  = 1'b1;
            clr     = 1'b1;
            fv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            inc   = 1'b1;
            sh_we = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      y_q     <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
      for (int k = 0; k < NUM_CH - 1; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
      for (int k = 0; k < NUM_CH - 1; k++) begin
        if (sh_we && sh_idx == SLOT_W'(k)) begin
          shadow_q[k] <= din;
        end
      end
      if (commit) begin
        for (int k = 0; k < NUM_CH - 1; k++) begin
          y_q[k*WIDTH +: WIDTH] <= shadow_q[k];
        end
        y_q[(NUM_CH-1)*WIDTH +: WIDTH] <= din;
      end
    end
  end

  assign y           = y_q;
  assign frame_valid = fv_q;
  assign sync_err    = se_q;

endmodule

// File: tb/tb_demux4_tdm.sv
// Directed and random stimulus for demux4_tdm, checked against a
// queue-based frame model after every clock edge.
module tb_demux4_tdm;

  localparam int W = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          frame_start;
  logic [W-1:0]  din;
  logic [4*W-1:0] y;
  logic          frame_valid;
  logic [1:0]    slot;
  logic          sync_err;

  demux4_tdm #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .frame_start (frame_start),
    .din         (din),
    .y           (y),
    .frame_valid (frame_valid),
    .slot        (slot),
    .sync_err    (sync_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass;
  int n_total;

  logic [W-1:0]   mq[$];
  logic [4*W-1:0] m_y;
  logic           m_fv;
  logic           m_se;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_y  = '0;
    m_fv = 1'b0;
    m_se = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".y"}, 32'(y), 32'(m_y));
    chk({tag, ".fv"}, 32'(frame_valid), 32'(m_fv));
    chk({tag, ".slot"}, 32'(slot), 32'(mq.size()));
    chk({tag, ".se"}, 32'(sync_err), 32'(m_se));
  endtask

  // Frame-level model: a frame is the list of samples since frame_start
  task automatic step(input string tag, input logic v, input logic fs,
                      input logic [W-1:0] d);
    in_valid    = v;
    frame_start = fs;
    din         = d;
    @(posedge clk);
    m_fv = 1'b0;
    m_se = 1'b0;
    if (v) begin
      if (fs) begin
        m_se = (mq.size() != 0);
        mq.delete();
        mq.push_back(d);
      end else if (mq.size() == 0) begin
        m_se = 1'b1;
      end else begin
        mq.push_back(d);
        if (mq.size() == 4) begin
          m_y  = {mq[3], mq[2], mq[1], mq[0]};
          m_fv = 1'b1;
          mq.delete();
        end
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, W'($urandom));
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    in_valid    = 1'b0;
    frame_start = 1'b0;
    din         = '0;
    rst_n       = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("basic0", 1'b1, 1'b1, 4'hA);
    step("basic1", 1'b1, 1'b0, 4'hB);
    step("basic2", 1'b1, 1'b0, 4'hC);
    step("basic3", 1'b1, 1'b0, 4'hD);
    chk("basic.y_const", 32'(y), 32'h0000_DCBA);
    chk("basic.fv_const", 32'(frame_valid), 32'd1);
    step("basic_after", 1'b0, 1'b0, 4'h0);
    chk("basic.fv_drop", 32'(frame_valid), 32'd0);

    step("gap0", 1'b1, 1'b1, 4'hA);
    idle("gapA", 2);
    chk("gap.slot_hold", 32'(slot), 32'd1);
    step("gap1", 1'b1, 1'b0, 4'hB);
    idle("gapB", 2);
    step("gap2", 1'b1, 1'b0, 4'hC);
    idle("gapC", 2);
    step("gap3", 1'b1, 1'b0, 4'hD);
    chk("gap.y_const", 32'(y), 32'h0000_DCBA);
    idle("gapD", 1);

    step("early0", 1'b1, 1'b1, 4'h1);
    step("early1", 1'b1, 1'b0, 4'h2);
    step("early2", 1'b1, 1'b1, 4'h5);
    chk("early.se_const", 32'(sync_err), 32'd1);
    chk("early.y_held", 32'(y), 32'h0000_DCBA);
    step("early3", 1'b1, 1'b0, 4'h6);
    step("early4", 1'b1, 1'b0, 4'h7);
    step("early5", 1'b1, 1'b0, 4'h8);
    chk("early.y_const", 32'(y), 32'h0000_8765);

    step("unsync", 1'b1, 1'b0, 4'h3);
    chk("unsync.se_const", 32'(sync_err), 32'd1);
    step("unsync_after", 1'b0, 1'b1, 4'h0);

    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        step("b2b", 1'b1, s == 0, W'(4 * f + s + 1));
      end
    end
    chk("b2b.y_const", 32'(y), 32'h0000_8765);

    // Asynchronous reset mid-frame, sampled away from any clock edge
    step("pre_rst0", 1'b1, 1'b1, 4'h9);
    step("pre_rst1", 1'b1, 1'b0, 4'h4);
    rst_n = 1'b0;
    model_reset();
    #2;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_rst", 1'b1, 1'b0, 4'hE);

    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom_range(3) != 0), ($urandom_range(4) == 0),
           W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/demux4_tdm.md
# demux4_tdm

Time-division 1-to-4 demultiplexer: the receive-side counterpart of the 4:1 mux. A frame is four consecutive valid samples on a single input bus, slot 0 first. The block steers each sample into a per-channel shadow register and commits all four channels to the outputs atomically when the frame completes. It flags framing violations and sits directly behind a TDM source that scans select 0..3.

## Interface
- `WIDTH`, default 4: sample width in bits.
- `clk` — input, 1 bit. Rising-edge clock.
- `rst_n` — input, 1 bit. Asynchronous, active-low reset.
- `in_valid` — input, 1 bit. `din` carries a sample this cycle.
- `frame_start` — input, 1 bit. Qualified by `in_valid`; marks the slot-0 sample.
- `din` — input, `WIDTH` bits. Sample data.
- `y` — output, 4*`WIDTH` bits. Channel k occupies `y[k*WIDTH +: WIDTH]`; registered.
- `frame_valid` — output, 1 bit. One-cycle pulse: `y` was just updated with a complete frame.
- `slot` — output, 2 bits. Slot index expected for the next accepted sample.
- `sync_err` — output, 1 bit. One-cycle pulse on a framing violation.

## Operation
- Reset (`rst_n`=0, asynchronous) forces:
  - state IDLE;
  - `slot`=0, `y`=0, shadow registers=0;
  - `frame_valid`=0, `sync_err`=0.
- States are IDLE (waiting for slot 0) and COLLECT (slots 1..3 pending).
- Cycles with `in_valid`=0: no state change; `frame_start` is ignored.
- IDLE:
  - `in_valid`&`frame_start`: shadow[0]<=`din`, `slot`<=1, go to COLLECT.
  - `in_valid`&!`frame_start`: sample dropped, `sync_err` pulses, stay in IDLE.
- COLLECT:
  - `in_valid`&!`frame_start`: shadow[`slot`]<=`din`, `slot`<=`slot`+1.
  - When `slot`==3, the sample goes directly into channel 3 of `y`, together with shadow[0..2] into channels 0..2, all in one edge. `frame_valid` pulses, `slot` wraps to 0, state goes to IDLE.
  - `in_valid`&`frame_start` (frame restarted early): `sync_err` pulses and the partial frame is discarded. shadow[0]<=`din`, `slot`<=1, stay in COLLECT. `y` is untouched.
- `y` holds its last committed frame until the next commit. A partial frame never reaches `y`.
- `slot` arithmetic is 2-bit modulo 4; 3 wraps to 0 only on commit.

## Timing
- All outputs are registered and change only on a `clk` rising edge, apart from the asynchronous reset.
- Commit latency: the edge that samples slot 3 updates `y`, and `frame_valid` is high in the following cycle. That is 1 cycle after the last sample is presented.
- Back-to-back frames:
  - A `frame_start` sample in the cycle immediately after slot 3 is accepted with no bubble.
  - Sustained throughput is one frame per 4 valid cycles.
- `sync_err` and `frame_valid` are mutually exclusive in any cycle. `sync_err` is high the cycle after the offending sample.
- `in_valid` gaps inside a frame are allowed and of any length; `slot` holds across them.
- Reset asserted mid-frame discards the frame immediately. After `rst_n` deasserts, the first accepted sample must carry `frame_start`.

## Structure
- Package `demux_pkg`: state enum (IDLE, COLLECT), `NUM_CH`=4, `SLOT_W`=2.
- Sub-module `demux_slot_ctr`: modulo-4 slot counter with load-to-1, increment, and clear inputs. It produces `slot` and a `last_slot` flag. The top level holds the FSM, the shadow registers and the `y` output registers.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run → `y`=0, `slot`=0, `frame_valid`=0 and `sync_err`=0 immediately, without waiting for a clock edge.
- **Basic frame:** `WIDTH`=4, valid samples A,B,C,D with `frame_start` on A → the next cycle shows `y`=16'hDCBA, `frame_valid`=1 for exactly one cycle, and `slot` back at 0.
- **Gapped input:** the same frame with 2 idle cycles between each sample → identical `y`; `slot` holds during the gaps; `frame_valid` follows D by 1 cycle.
- **Early restart:** `frame_start` samples 1,2 then `frame_start` samples 5,6,7,8 → `sync_err` pulses once after the third sample, then `y`=16'h8765 with `frame_valid`; the earlier `y` value is held until then.
- **Unsynced input:** a sample without `frame_start` while in IDLE → `sync_err`=1 for one cycle, `slot` stays 0, `y` unchanged.
- **Back-to-back:** two frames with no idle cycles between them → two `frame_valid` pulses 4 cycles apart, each carrying its own data, with no `sync_err`.
